// File: rtl/pipelined_addsub.sv
// pipelined_addsub: registered add/subtract with the carry chain cut into STAGES segments.
//
// Stage 0 registers the operands; stage k (1..STAGES) adds segment k-1 using the
// registered carry of stage k-1. The final stage also forms the borrow/carry bit
// and the signed-overflow flag, so sum/ovf/out_valid come straight from registers.
// The whole pipeline advances together whenever the output is free or being taken.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset (clears every register)
//   in_valid   operand beat present
//   in_ready   beat accepted this cycle (combinational from out_ready)
//   a, b       WIDTH-bit operands
//   sub        0: a+b, 1: a-b
//   out_valid  result present
//   out_ready  downstream takes the result
//   sum        WIDTH+1-bit result; top bit is carry (add) or borrow (subtract)
//   ovf        two's-complement overflow of the WIDTH-bit result
module pipelined_addsub #(
  parameter int unsigned WIDTH  = 69,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             ovf
);

  localparam int unsigned Seg    = (WIDTH + STAGES - 1) / STAGES;
  localparam int unsigned Pw     = STAGES * Seg;
  localparam int unsigned LoLast = (STAGES - 1) * Seg;
  localparam int unsigned Last   = WIDTH - LoLast;
  // Operands are zero-padded to Pw bits; only real bits of B get inverted on subtract.
  localparam logic [Pw-1:0] Mask = Pw'({WIDTH{1'b1}});

  if (WIDTH < 1 || STAGES < 1 || LoLast >= WIDTH) begin : g_param_check
    $error("pipelined_addsub: WIDTH/STAGES leave an empty last segment");
  end

  // Index k holds the beat that has completed stage k (k = 0 is the input register).
  logic [Pw-1:0] opa_q [STAGES];
  logic [Pw-1:0] opa_d [STAGES];
  logic [Pw-1:0] opb_q [STAGES];
  logic [Pw-1:0] opb_d [STAGES];
  logic [Pw-1:0] res_q [STAGES];
  logic [Pw-1:0] res_d [STAGES];
  logic          sub_q [STAGES];
  logic          sub_d [STAGES];
  logic          cry_q [STAGES];
  logic          cry_d [STAGES];
  logic          vld_q [STAGES+1];
  logic          vld_d [STAGES+1];
  logic [WIDTH:0] sum_q, sum_d;
  logic           ovf_q, ovf_d;

  logic           adv;
  logic [Seg:0]   mid_seg;
  logic [Seg:0]   last_seg;
  logic           a_msb, b_msb;
  logic           unused_seg;

  // One Seg-bit carry chain: segment idx of x plus (optionally inverted) segment of y.
  function automatic logic [Seg:0] seg_add(input logic [Pw-1:0] x, input logic [Pw-1:0] y,
                                           input logic inv, input logic cin,
                                           input int unsigned idx);
    logic [Seg-1:0] xs, ys, ms;
    xs = x[idx*Seg +: Seg];
    ys = y[idx*Seg +: Seg];
    ms = Mask[idx*Seg +: Seg];
    return {1'b0, xs} + {1'b0, ys ^ (ms & {Seg{inv}})} + {{Seg{1'b0}}, cin};
  endfunction

  assign adv       = out_ready | ~vld_q[STAGES];
  assign in_ready  = adv;
  assign out_valid = vld_q[STAGES];
  assign sum       = sum_q;
  assign ovf       = ovf_q;

  always_comb begin
    mid_seg = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      opa_d[k] = opa_q[k];
      opb_d[k] = opb_q[k];
      res_d[k] = res_q[k];
      sub_d[k] = sub_q[k];
      cry_d[k] = cry_q[k];
      vld_d[k] = vld_q[k];
    end
    vld_d[STAGES] = vld_q[STAGES];

    // Stage 0: the subtract carry-in rides along as the first segment's carry.
    opa_d[0] = Pw'(a);
    opb_d[0] = Pw'(b);
    res_d[0] = '0;
    sub_d[0] = sub;
    cry_d[0] = sub;
    vld_d[0] = in_valid;

    for (int unsigned k = 1; k < STAGES; k++) begin
      mid_seg  = seg_add(opa_q[k-1], opb_q[k-1], sub_q[k-1], cry_q[k-1], k - 1);
      opa_d[k] = opa_q[k-1];
      opb_d[k] = opb_q[k-1];
      res_d[k] = res_q[k-1];
      res_d[k][(k-1)*Seg +: Seg] = mid_seg[Seg-1:0];
      sub_d[k] = sub_q[k-1];
      cry_d[k] = mid_seg[Seg];
      vld_d[k] = vld_q[k-1];
    end
    vld_d[STAGES] = vld_q[STAGES-1];

    // Last segment: padding above Last is zero, so its carry-out lands on bit Last.
    last_seg = seg_add(opa_q[STAGES-1], opb_q[STAGES-1], sub_q[STAGES-1], cry_q[STAGES-1],
                       STAGES - 1);
    sum_d                 = {1'b0, res_q[STAGES-1][WIDTH-1:0]};
    sum_d[LoLast +: Last] = last_seg[Last-1:0];
    sum_d[WIDTH]          = last_seg[Last] ^ sub_q[STAGES-1];

    a_msb = opa_q[STAGES-1][WIDTH-1];
    b_msb = opb_q[STAGES-1][WIDTH-1];
    ovf_d = (sub_q[STAGES-1] ? (a_msb != b_msb) : (a_msb == b_msb)) &&
            (sum_d[WIDTH-1] != a_msb);
  end

  assign unused_seg = ^last_seg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        opa_q[k] <= '0;
        opb_q[k] <= '0;
        res_q[k] <= '0;
        sub_q[k] <= 1'b0;
        cry_q[k] <= 1'b0;
      end
      for (int unsigned k = 0; k <= STAGES; k++) begin
        vld_q[k] <= 1'b0;
      end
      sum_q <= '0;
      ovf_q <= 1'b0;
    end else if (adv) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        opa_q[k] <= opa_d[k];
        opb_q[k] <= opb_d[k];
        res_q[k] <= res_d[k];
        sub_q[k] <= sub_d[k];
        cry_q[k] <= cry_d[k];
      end
      for (int unsigned k = 0; k <= STAGES; k++) begin
        vld_q[k] <= vld_d[k];
      end
      sum_q <= sum_d;
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: directed and random checks of pipelined_addsub (WIDTH=69, STAGES=4).
// A stall-all pipeline of STAGES+1 slots is modelled with plain integer arithmetic;
// every cycle the DUT outputs and in_ready are compared against it.
module tb_pipelined_addsub;

  localparam int unsigned W   = 69;
  localparam int unsigned S   = 4;
  localparam int unsigned Lat = S + 1;

  localparam logic signed [W+1:0] MaxS = {3'b000, {(W-1){1'b1}}};
  localparam logic signed [W+1:0] MinS = {3'b111, {(W-1){1'b0}}};

  typedef struct packed {
    logic         v;
    logic [W:0]   s;
    logic         o;
  } ent_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   sum;
  logic         ovf;

  int   errors;
  int   checks;
  int   acc_cnt;
  int   del_cnt;
  ent_t pipe [Lat];

  pipelined_addsub #(
    .WIDTH (W),
    .STAGES(S)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact arithmetic; overflow means the signed result leaves the W-bit range.
  function automatic ent_t ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic s);
    ent_t e;
    logic signed [W+1:0] xs, ys, t;
    xs = $signed({{2{x[W-1]}}, x});
    ys = $signed({{2{y[W-1]}}, y});
    if (s) begin
      e.s = {1'b0, x} - {1'b0, y};
      t   = xs - ys;
    end else begin
      e.s = {1'b0, x} + {1'b0, y};
      t   = xs + ys;
    end
    e.o = (t > MaxS) || (t < MinS);
    e.v = 1'b1;
    return e;
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    case ($urandom_range(0, 7))
      0:       return {W{1'b1}};
      1:       return '0;
      default: return r[W-1:0];
    endcase
  endfunction

  task automatic rnd_beat();
    logic [31:0] r;
    r        = $urandom();
    a        = rnd();
    b        = rnd();
    sub      = r[0];
    in_valid = 1'b1;
  endtask

  // One clock: check in_ready, advance the model at the edge, then check the outputs.
  task automatic tick();
    logic adv_m;
    ent_t nw;
    #1;
    adv_m = out_ready || !pipe[Lat-1].v;
    check("in_ready", in_ready, adv_m);
    if (rst_n && in_valid && adv_m) acc_cnt++;
    if (rst_n && out_valid && out_ready) del_cnt++;
    nw   = ref_op(a, b, sub);
    nw.v = in_valid;
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < Lat; i++) pipe[i] = '0;
    end else if (adv_m) begin
      for (int i = Lat - 1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = nw;
    end
    #1;
    check("out_valid", out_valid, pipe[Lat-1].v);
    if (pipe[Lat-1].v) begin
      check("sum", sum, pipe[Lat-1].s);
      check("ovf", ovf, pipe[Lat-1].o);
    end
    if (!rst_n) begin
      check("rst_sum", sum, 0);
      check("rst_ovf", ovf, 0);
    end
  endtask

  task automatic send_one(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic s, input logic [W:0] es, input logic eo);
    int n;
    a         = x;
    b         = y;
    sub       = s;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n        = 1;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, n, Lat);
    check({tag, "_sum"}, sum, es);
    check({tag, "_ovf"}, ovf, eo);
    tick();
  endtask

  initial begin
    int rel, first, cnt, last, n;
    errors    = 0;
    checks    = 0;
    acc_cnt   = 0;
    del_cnt   = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    sub       = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < Lat; i++) pipe[i] = '0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_sum", sum, 0);
    check("reset_ovf", ovf, 0);
    out_ready = 1'b0;
    #1;
    check("reset_in_ready", in_ready, 1);
    out_ready = 1'b1;
    rst_n     = 1'b1;
    tick();

    // Max add, segment-boundary carries, subtract cases.
    send_one("max_add", {W{1'b1}}, {W{1'b1}}, 1'b0, {{W{1'b1}}, 1'b0}, 1'b0);
    send_one("seg18", 69'h3FFFF, 69'd1, 1'b0, 70'h40000, 1'b0);
    send_one("seg36", 69'hF_FFFF_FFFF, 69'd1, 1'b0, 70'h10_0000_0000, 1'b0);
    send_one("seg54", 69'h3F_FFFF_FFFF_FFFF, 69'd1, 1'b0, 70'h40_0000_0000_0000, 1'b0);
    send_one("sub_borrow", 69'd5, 69'd7, 1'b1, {{W{1'b1}}, 1'b0}, 1'b0);
    send_one("sub_ovf", 69'h1_0000_0000_0000_0000_0, 69'd1, 1'b1,
             70'hF_FFFF_FFFF_FFFF_FFFF, 1'b1);

    // Back-to-back random beats.
    rel   = 0;
    first = 0;
    cnt   = 0;
    last  = 0;
    for (int i = 0; i < 30; i++) begin
      if (i < 20) rnd_beat();
      else in_valid = 1'b0;
      tick();
      rel++;
      if (out_valid) begin
        if (first == 0) first = rel;
        last = rel;
        cnt++;
      end
    end
    check("b2b_first", first, Lat);
    check("b2b_count", cnt, 20);
    check("b2b_last", last, Lat + 19);

    // Backpressure: fill until a result shows, stall 3 cycles while still offering beats.
    acc_cnt = 0;
    del_cnt = 0;
    n       = 0;
    while (!out_valid && n < 10) begin
      rnd_beat();
      tick();
      n++;
    end
    check("bp_fill", out_valid, 1);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rnd_beat();
      tick();
      check("bp_stall_in_ready", in_ready, 0);
      check("bp_stall_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rnd_beat();
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("bp_no_loss", del_cnt, acc_cnt);

    // Mid-run reset with three beats in flight; a beat offered during reset is dropped.
    for (int i = 0; i < 3; i++) begin
      rnd_beat();
      tick();
    end
    rnd_beat();
    rst_n = 1'b0;
    tick();
    check("mrst_valid", out_valid, 0);
    rst_n = 1'b1;
    send_one("after_rst", 69'd100, 69'd23, 1'b0, 70'd123, 1'b0);
    for (int i = 0; i < 6; i++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
